// File: rtl/ringbuffer_uart_drain.sv
// ringbuffer_uart_drain: pops ring-buffer records and sends them MSB byte first over an 8N1 UART line
module ringbuffer_uart_drain #(
  parameter int DW = 48,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          empty,
  input  logic [DW-1:0] read_data,
  output logic          read_clk_enable,
  output logic          uart_tx,
  output logic          busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NB = DW / 8;
  localparam int BW = $clog2(NB) + 1;
  typedef enum logic [2:0] {IDLE, POP, WAIT, START, DATA, STOP} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [BW-1:0] byte_idx;
  logic [DW-1:0] shift_reg;
  logic [7:0]    cur_byte;
  logic          bit_end;
  assign cur_byte = shift_reg[DW-1 -: 8];
  assign bit_end  = cnt == CW'(CLKS_PER_BIT - 1);
  // uart_tx is loaded one cycle ahead with the level of the bit about to start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      byte_idx        <= '0;
      shift_reg       <= '0;
      read_clk_enable <= 1'b0;
      uart_tx         <= 1'b1;
      busy            <= 1'b0;
    end else begin
      read_clk_enable <= 1'b0;
      case (state)
        IDLE: if (!empty) begin
          read_clk_enable <= 1'b1;
          busy            <= 1'b1;
          state           <= POP;
        end
        POP: state <= WAIT;
        WAIT: begin
          shift_reg <= read_data;
          byte_idx  <= '0;
          cnt       <= '0;
          uart_tx   <= 1'b0;
          state     <= START;
        end
        START: if (bit_end) begin
          cnt     <= '0;
          bit_idx <= '0;
          uart_tx <= cur_byte[0];
          state   <= DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (bit_end) begin
          cnt <= '0;
          if (bit_idx == 3'd7) begin
            uart_tx <= 1'b1;
            state   <= STOP;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            uart_tx <= cur_byte[bit_idx + 3'd1];
          end
        end else cnt <= cnt + 1'b1;
        STOP: if (bit_end) begin
          cnt       <= '0;
          shift_reg <= shift_reg << 8;
          if (byte_idx == BW'(NB - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            uart_tx  <= 1'b0;
            state    <= START;
          end
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ringbuffer_uart_drain.sv
// tb_ringbuffer_uart_drain: queue-based ring buffer model and UART line decoder checking the drain stage
module tb_ringbuffer_uart_drain;
  localparam int DW = 48;
  localparam int CPB = 4;
  localparam int NB = DW / 8;
  logic clk = 1'b0, reset = 1'b0, empty, read_clk_enable, uart_tx, busy;
  logic [DW-1:0] read_data;
  logic [DW-1:0] buf_q[$];
  logic [DW-1:0] rd_reg = '0, noise_data = '0;
  logic noise_en = 1'b0, noise_empty = 1'b0, in_wait = 1'b0, prev_rce = 1'b0;
  int q_len = 0, cyc = 0, pops = 0, busy_cnt = 0, act = 0, frame_err = 0;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] got_q[$], exp_q[$];
  int st_q[$], pc_q[$];

  ringbuffer_uart_drain #(.DW(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .empty(empty), .read_data(read_data),
    .read_clk_enable(read_clk_enable), .uart_tx(uart_tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // noise is only shown to the DUT while busy, except across the pop/capture window
  assign empty     = (noise_en && busy) ? noise_empty : (q_len == 0);
  assign read_data = (noise_en && busy && !in_wait) ? noise_data : rd_reg;

  always @(negedge clk) begin
    in_wait  = read_clk_enable || prev_rce;
    prev_rce = read_clk_enable;
    if (read_clk_enable) begin
      pops++;
      pc_q.push_back(cyc);
      if (buf_q.size() > 0) rd_reg = buf_q.pop_front();
      q_len = buf_q.size();
    end
    if (busy) busy_cnt++;
    if (!uart_tx || read_clk_enable || busy) act++;
    noise_empty = 1'($urandom_range(0, 1));
    noise_data  = DW'({$urandom(), $urandom()});
  end

  initial begin
    logic s [40];
    logic [7:0] b;
    bit ab, bad;
    int c0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && uart_tx === 1'b0) begin
        c0 = cyc;
        s[0] = 1'b0;
        ab = 1'b0;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (reset !== 1'b1) begin ab = 1'b1; break; end
          s[k] = uart_tx;
        end
        if (!ab) begin
          bad = s[36] !== 1'b1;
          for (int j = 0; j < 10; j++)
            for (int m = 1; m < CPB; m++)
              if (s[CPB*j+m] !== s[CPB*j]) bad = 1'b1;
          for (int j = 0; j < 8; j++) b[j] = s[CPB*(j+1)];
          if (bad) frame_err++;
          got_q.push_back(b);
          st_q.push_back(c0);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] r, input bit model);
    buf_q.push_back(r);
    q_len = buf_q.size();
    if (model) for (int i = NB - 1; i >= 0; i--) exp_q.push_back(8'(r >> (8 * i)));
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int k = 0;
    while (got_q.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("wait_bytes", 64'(got_q.size() >= n), 1);
  endtask

  task automatic compare_bytes(input string tag);
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    check({tag, "_leftover"}, 64'(got_q.size() + exp_q.size()), 0);
  endtask

  task automatic clear_logs();
    st_q.delete();
    pc_q.delete();
  endtask

  function automatic int st_at(input int i);
    return (i < st_q.size()) ? st_q[i] : -1000;
  endfunction

  function automatic int pc_at(input int i);
    return (i < pc_q.size()) ? pc_q[i] : -1000;
  endfunction

  initial begin
    int p0, k;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    act = 0;
    repeat (500) @(negedge clk);
    check("idle_activity", act, 0);
    check("idle_tx", uart_tx, 1);
    check("idle_rce", read_clk_enable, 0);
    check("idle_busy", busy, 0);
    check("idle_pops", pops, 0);

    clear_logs();
    busy_cnt = 0;
    p0 = pops;
    push(48'h0123456789AB, 1);
    wait_bytes(6, 400);
    repeat (10) @(negedge clk);
    check("single_pops", pops - p0, 1);
    check("start_delay", st_at(0) - pc_at(0), 2);
    check("busy_cycles", busy_cnt, 2 + NB * 10 * CPB);
    check("record_span", st_at(5) - st_at(0), 5 * 10 * CPB);
    compare_bytes("single_byte");

    clear_logs();
    p0 = pops;
    push(48'hA5A5_0000_0001, 1);
    push(48'hA5A5_0000_0002, 1);
    push(48'hA5A5_0000_0003, 1);
    wait_bytes(18, 1200);
    repeat (10) @(negedge clk);
    check("burst_pops", pops - p0, 3);
    for (int r = 1; r < 3; r++) begin
      check("burst_gap", st_at(6*r) - st_at(6*r-1), 10 * CPB + 3);
      check("pop_after_stop", pc_at(r) - st_at(6*r-1), 10 * CPB + 1);
    end
    compare_bytes("burst_byte");

    clear_logs();
    push(48'h5555_5555_5555, 1);
    wait_bytes(6, 400);
    check("bit_timing_frames", frame_err, 0);
    check("byte_period", st_at(1) - st_at(0), 10 * CPB);
    compare_bytes("pattern55_byte");

    clear_logs();
    p0 = pops;
    noise_en = 1'b1;
    push(48'hC396_0FF0_5AA5, 1);
    wait_bytes(6, 400);
    repeat (20) @(negedge clk);
    noise_en = 1'b0;
    check("noise_pops", pops - p0, 1);
    compare_bytes("noise_byte");

    clear_logs();
    p0 = pops;
    for (int r = 0; r < 6; r++) begin
      push(DW'({$urandom(), $urandom()}), 1);
      repeat ($urandom_range(0, 120)) @(negedge clk);
    end
    wait_bytes(36, 3000);
    repeat (10) @(negedge clk);
    check("random_pops", pops - p0, 6);
    check("random_frames", frame_err, 0);
    compare_bytes("random_byte");

    clear_logs();
    p0 = pops;
    push(48'h1234_0056_7890, 0);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    k = 0;
    while (read_clk_enable !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reset_pop_seen", read_clk_enable, 1);
    repeat (93) @(negedge clk);
    check("reset_tx_before", uart_tx, 0);
    #1 reset = 1'b0;
    #1;
    check("reset_tx", uart_tx, 1);
    check("reset_busy", busy, 0);
    check("reset_rce", read_clk_enable, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    act = 0;
    repeat (200) @(negedge clk);
    check("post_reset_activity", act, 0);
    check("post_reset_pops", pops - p0, 1);
    check("post_reset_frames", frame_err, 0);
    compare_bytes("reset_byte");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
